matrix_stream_loader: RTL
=========================

# matrix_stream_loader

Parametrised successor to the UART matrix-input front end: consumes an already-deserialised byte stream, parses ASCII dimension/count/element tokens, and writes a matrix (user-typed or LFSR-generated) into matrix storage through a base-address handshake with the top FSM. Adds configurable dimension and element ranges, multi-matrix generation up to `MAX_GEN`, and per-matrix indexing. Optional signed element parsing is a compile-time feature. Sits between `uart_rx` and the storage write mux.

## Interface
- `DATA_W`, 32, element/data width
- `ADDR_W`, 9, storage address width
- `MAX_DIM`, 5, max legal m, n (min 1)
- `ELEM_MAX`, 9, max legal element magnitude
- `MAX_GEN`, 4, max matrices per generate request (min 1)
- `TIMEOUT_CYC`, 30_000_000, idle cycles before auto-finish/flush exit
- `LFSR_SEED`, 32'hACE1, LFSR reset value (nonzero)

- `clk` in 1 — system clock
- `rst_n` in 1 — reset; one clock; reset is synchronous and active-low
- `en` in 1 — enable from top FSM; low forces IDLE state and clears outputs next edge
- `rx_data` in 8 — received byte
- `rx_valid` in 1 — one-cycle strobe, `rx_data` valid
- `gen_mode` in 1 — 1 = generate, 0 = user input; sampled in S_DIM_N
- `base_addr` in ADDR_W — allocated base, valid while `addr_ready` high
- `addr_ready` in 1 — FSM grant for current matrix
- `dims_valid` out 1 — address request, held until grant
- `dim_m`, `dim_n` out DATA_W — accepted dimensions
- `mat_idx` out 8 — index of matrix being written (0-based)
- `mem_we` out 1 — storage write strobe
- `mem_addr` out ADDR_W — `base_addr` latched at grant + offset
- `mem_data` out DATA_W — write data
- `err` out 1 — token error, drives external countdown
- `done` out 1 — high in S_DONE until `en` low

## Operation
- Token: digits accumulate `acc = acc*10 + d` (saturate at 2^DATA_W−1); delimiter = space, CR, LF; any other byte = error.
- States: S_DIM_M → S_DIM_N → (gen: S_COUNT) → S_REQ → S_CLEAR (user only) → S_USER / S_GEN → S_DONE; S_FLUSH on error.
- S_DIM_M/S_DIM_N: delimiter with acc in [1,MAX_DIM] latches dim, acc←0, advance; out of range or bad byte sets `err`: terminating CR/LF → S_DIM_M, err cleared; space/bad byte → S_FLUSH.
- S_COUNT: acc in [1,MAX_GEN] latches total, else same error rule.
- S_REQ: `dims_valid`=1; on `addr_ready` latch `base_addr`, offset←0, `dims_valid`←0.
- S_CLEAR: writes 0 to offsets 0..m·n−1, one per cycle, then offset←0 → S_USER.
- S_USER: delimiter with valid acc writes acc at offset, offset+1; write of offset m·n−1 → S_DONE; CR/LF with no error → S_DONE (remaining cells stay 0); element > ELEM_MAX sets `err`, element discarded, user re-enters it at same offset; `err` cleared by next valid digit; delimiter while `err` → S_FLUSH.
- S_GEN: writes `lfsr % (ELEM_MAX+1)` to each offset, one per cycle; after last cell `mat_idx`+1; more remaining → S_REQ, else S_DONE.
- S_FLUSH: ignores bytes; CR/LF or timeout → S_DIM_M, `err`←0.
- Empty token (two delimiters) ignored in all parse states.
- LFSR: 32-bit, taps 31,21,1, advances every cycle, not gated by `en`.

## Timing
- Reset (and `en` low): all outputs 0, state S_DIM_M, acc 0, lfsr `LFSR_SEED`.
- All outputs registered; `mem_we` asserted the cycle after the accepting `rx_valid` edge, single-cycle.
- Grant latency: S_CLEAR/S_GEN begin the cycle after `addr_ready` sampled high.
- Clear and gen throughput: 1 write/cycle; m·n cycles per matrix.
- Timeout counter runs only in S_USER and S_FLUSH, reset by any `rx_valid`; at `TIMEOUT_CYC` S_USER → S_DONE (err clear) or S_DIM_M (err set).
- `rx_valid` with `en` low dropped; `addr_ready` outside S_REQ ignored.

## Configuration
- `MATRIX_STREAM_SIGNED_EN` defined: leading '-' in S_USER negates element (two's complement, DATA_W), range [−ELEM_MAX, ELEM_MAX]; generator emits `(lfsr % (2·ELEM_MAX+1)) − ELEM_MAX`; '-' elsewhere is an error.
- Undefined: '-' is an error byte everywhere; elements unsigned.

## Test plan
- "2 3\n" then grant base 40, "1 2 3 4 5 6 " -> 6 zero writes 40..45, then writes 1..6 at 40..45, `done`=1 after 6th.
- "2 2\n", grant base 0, "7\n" -> addr 0 = 7, addr 1..3 = 0, `done`=1.
- "6 " then "x y\n" -> `err`=1, S_FLUSH, `err`=0 after LF, next "1 1\n" raises `dims_valid`.
- gen_mode=1, "2 2 3\n", three grants at 0/4/8 -> 12 writes, each ≤ ELEM_MAX, `mat_idx` 0→1→2, `done`.
- "1 2\n", grant, "12 " -> `err`=1, no write; "5 3 " -> writes 5, 3, `done`.
- Signed build: "1 1\n", grant, "-4\n" -> `mem_data`=32'hFFFFFFFC.

Source files
------------

// File: rtl/matrix_stream_if.sv
// Byte-stream, address-grant and storage-write bundle between the top FSM side
// (master) and matrix_stream_loader (slave).
interface matrix_stream_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              en;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              gen_mode;
    logic [ADDR_W-1:0] base_addr;
    logic              addr_ready;
    logic              dims_valid;
    logic [DATA_W-1:0] dim_m;
    logic [DATA_W-1:0] dim_n;
    logic [7:0]        mat_idx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              err;
    logic              done;

    modport master (
        output en, rx_data, rx_valid, gen_mode, base_addr, addr_ready,
        input  dims_valid, dim_m, dim_n, mat_idx, mem_we, mem_addr, mem_data, err, done
    );

    modport slave (
        input  en, rx_data, rx_valid, gen_mode, base_addr, addr_ready,
        output dims_valid, dim_m, dim_n, mat_idx, mem_we, mem_addr, mem_data, err, done
    );
endinterface

// File: rtl/matrix_stream_loader.sv
// ASCII matrix loader: parses dimension/count/element tokens and writes user or LFSR matrices
// into storage. Define MATRIX_STREAM_SIGNED_EN for signed ('-' prefixed) elements.
module matrix_stream_loader #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 9,
    parameter int          MAX_DIM     = 5,
    parameter int          ELEM_MAX    = 9,
    parameter int          MAX_GEN     = 4,
    parameter int          TIMEOUT_CYC = 30_000_000,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1
) (
    input  logic           clk,
    input  logic           rst_n,
    matrix_stream_if.slave io_bus
);
    localparam logic [3:0] S_DIM_M = 4'd0;
    localparam logic [3:0] S_DIM_N = 4'd1;
    localparam logic [3:0] S_COUNT = 4'd2;
    localparam logic [3:0] S_REQ   = 4'd3;
    localparam logic [3:0] S_CLEAR = 4'd4;
    localparam logic [3:0] S_USER  = 4'd5;
    localparam logic [3:0] S_GEN   = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_FLUSH = 4'd8;

    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W-1:0] DIM_LIM  = DATA_W'(MAX_DIM);
    localparam logic [DATA_W-1:0] GEN_LIM  = DATA_W'(MAX_GEN);
    localparam logic [DATA_W-1:0] ELEM_LIM = DATA_W'(ELEM_MAX);

    logic [3:0]        r_state;
    logic [DATA_W-1:0] r_acc;
    logic              r_tok;
    logic              r_neg;
    logic [DATA_W-1:0] r_dim_m;
    logic [DATA_W-1:0] r_dim_n;
    logic [7:0]        r_total;
    logic [7:0]        r_mat_idx;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_offset;
    logic [ADDR_W-1:0] r_mn;
    logic              r_gen_mode;
    logic              r_dims_valid;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_err;
    logic              r_done;
    logic [31:0]       r_lfsr;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_rx;
    logic              w_digit;
    logic              w_eol;
    logic              w_delim;
    logic              w_pending;
    logic [DATA_W-1:0] w_lim;
    logic              w_in_range;
    logic              w_elem_ok;
    logic [ADDR_W-1:0] w_last;
    logic              w_tmo_run;
    logic              w_tmo_hit;
`ifdef MATRIX_STREAM_SIGNED_EN
    logic              w_minus;
    assign w_minus = (io_bus.rx_data == 8'h2D);
`endif

    // Decimal accumulate, clamped to the all-ones value instead of wrapping
    function automatic logic [DATA_W-1:0] acc_step(input logic [DATA_W-1:0] a,
                                                   input logic [7:0] b);
        logic [7:0]        d;
        logic [DATA_W+4:0] t;
        d = b - 8'h30;
        t = ({5'd0, a} << 3) + ({5'd0, a} << 1) + {{(DATA_W-3){1'b0}}, d};
        if (|t[DATA_W+4:DATA_W]) return '1;
        return t[DATA_W-1:0];
    endfunction

`ifdef MATRIX_STREAM_SIGNED_EN
    function automatic logic [DATA_W-1:0] elem_apply(input logic [DATA_W-1:0] a, input logic n);
        logic signed [DATA_W-1:0] s;
        s = $signed(a);
        return n ? -s : s;
    endfunction

    function automatic logic [DATA_W-1:0] gen_elem(input logic [31:0] l);
        logic signed [DATA_W-1:0] v;
        v = $signed(DATA_W'(l % 32'(2 * ELEM_MAX + 1))) - $signed(ELEM_LIM);
        return v;
    endfunction
`else
    function automatic logic [DATA_W-1:0] gen_elem(input logic [31:0] l);
        return DATA_W'(l % 32'(ELEM_MAX + 1));
    endfunction
`endif

    assign w_rx       = io_bus.rx_valid;
    assign w_digit    = (io_bus.rx_data >= 8'h30) && (io_bus.rx_data <= 8'h39);
    assign w_eol      = (io_bus.rx_data == 8'h0D) || (io_bus.rx_data == 8'h0A);
    assign w_delim    = w_eol || (io_bus.rx_data == 8'h20);
    assign w_pending  = r_tok || r_neg;
    assign w_lim      = (r_state == S_COUNT) ? GEN_LIM : DIM_LIM;
    assign w_in_range = r_tok && (r_acc != '0) && (r_acc <= w_lim);
    assign w_elem_ok  = r_tok && (r_acc <= ELEM_LIM);
    assign w_last     = r_mn - ADDR_W'(1);
    assign w_tmo_run  = (r_state == S_USER) || (r_state == S_FLUSH);
    assign w_tmo_hit  = w_tmo_run && (r_tmo == TMO_LAST);

    // Free-running generator; only a real reset reseeds it
    always_ff @(posedge clk) begin
        if (!rst_n) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !io_bus.en || !w_tmo_run || w_rx) r_tmo <= '0;
        else if (!w_tmo_hit)                            r_tmo <= r_tmo + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !io_bus.en) begin
            r_state      <= S_DIM_M;
            r_acc        <= '0;
            r_tok        <= 1'b0;
            r_neg        <= 1'b0;
            r_dim_m      <= '0;
            r_dim_n      <= '0;
            r_total      <= '0;
            r_mat_idx    <= '0;
            r_base       <= '0;
            r_offset     <= '0;
            r_mn         <= '0;
            r_gen_mode   <= 1'b0;
            r_dims_valid <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_DIM_M, S_DIM_N, S_COUNT: begin
                    if (w_rx) begin
                        if (w_digit) begin
                            r_acc <= acc_step(r_acc, io_bus.rx_data);
                            r_tok <= 1'b1;
                        end else if (w_delim && !r_tok) begin
                            r_acc <= '0;
                        end else if (w_delim && w_in_range) begin
                            r_acc <= '0;
                            r_tok <= 1'b0;
                            if (r_state == S_DIM_M) begin
                                r_dim_m <= r_acc;
                                r_state <= S_DIM_N;
                            end else if (r_state == S_DIM_N) begin
                                r_dim_n    <= r_acc;
                                r_mn       <= ADDR_W'(r_dim_m * r_acc);
                                r_gen_mode <= io_bus.gen_mode;
                                r_mat_idx  <= '0;
                                r_total    <= 8'd1;
                                if (io_bus.gen_mode) begin
                                    r_state <= S_COUNT;
                                end else begin
                                    r_state      <= S_REQ;
                                    r_dims_valid <= 1'b1;
                                end
                            end else begin
                                r_total      <= 8'(r_acc);
                                r_state      <= S_REQ;
                                r_dims_valid <= 1'b1;
                            end
                        end else begin
                            // Bad value or byte: a line end restarts cleanly, anything else flushes
                            r_acc <= '0;
                            r_tok <= 1'b0;
                            if (w_delim && w_eol) begin
                                r_state <= S_DIM_M;
                                r_err   <= 1'b0;
                            end else begin
                                r_state <= S_FLUSH;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (io_bus.addr_ready) begin
                        r_base       <= io_bus.base_addr;
                        r_offset     <= '0;
                        r_dims_valid <= 1'b0;
                        r_state      <= r_gen_mode ? S_GEN : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_base + r_offset;
                    r_mem_data <= '0;
                    if (r_offset == w_last) begin
                        r_offset <= '0;
                        r_state  <= S_USER;
                    end else begin
                        r_offset <= r_offset + ADDR_W'(1);
                    end
                end
                S_USER: begin
                    if (w_rx) begin
                        if (w_digit) begin
                            r_err <= 1'b0;
                            r_acc <= acc_step(r_acc, io_bus.rx_data);
                            r_tok <= 1'b1;
                        end
`ifdef MATRIX_STREAM_SIGNED_EN
                        else if (w_minus && !r_tok && !r_neg) begin
                            r_neg <= 1'b1;
                        end
`endif
                        else if (w_delim) begin
                            r_acc <= '0;
                            r_tok <= 1'b0;
                            r_neg <= 1'b0;
                            if (r_err) begin
                                r_state <= S_FLUSH;
                            end else if (w_elem_ok) begin
                                r_mem_we   <= 1'b1;
                                r_mem_addr <= r_base + r_offset;
`ifdef MATRIX_STREAM_SIGNED_EN
                                r_mem_data <= elem_apply(r_acc, r_neg);
`else
                                r_mem_data <= r_acc;
`endif
                                if (r_offset == w_last || w_eol) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_offset <= r_offset + ADDR_W'(1);
                                end
                            end else if (w_pending) begin
                                // Rejected element: offset holds so the user can retype it
                                r_err <= 1'b1;
                            end else if (w_eol) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_err <= 1'b1;
                            r_acc <= '0;
                            r_tok <= 1'b0;
                            r_neg <= 1'b0;
                        end
                    end else if (w_tmo_hit) begin
                        if (r_err) begin
                            r_state <= S_DIM_M;
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_GEN: begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_base + r_offset;
                    r_mem_data <= gen_elem(r_lfsr);
                    if (r_offset == w_last) begin
                        r_offset  <= '0;
                        r_mat_idx <= r_mat_idx + 8'd1;
                        if ((r_mat_idx + 8'd1) < r_total) begin
                            r_state      <= S_REQ;
                            r_dims_valid <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_offset <= r_offset + ADDR_W'(1);
                    end
                end
                S_FLUSH: begin
                    if ((w_rx && w_eol) || w_tmo_hit) begin
                        r_state <= S_DIM_M;
                        r_err   <= 1'b0;
                        r_acc   <= '0;
                        r_tok   <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= S_DIM_M;
                end
            endcase
        end
    end

    assign io_bus.dims_valid = r_dims_valid;
    assign io_bus.dim_m      = r_dim_m;
    assign io_bus.dim_n      = r_dim_n;
    assign io_bus.mat_idx    = r_mat_idx;
    assign io_bus.mem_we     = r_mem_we;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_data   = r_mem_data;
    assign io_bus.err        = r_err;
    assign io_bus.done       = r_done;
endmodule
